dma_wr_arb: RTL and testbench

Two-channel arbiter that shares one DMA write engine between two video-buffer write channels, e.g. two camera capture paths, in the `CLK` domain. Each channel presents a frame-line DMA request (address, size, request strobe) and a write-data stream. The arbiter selects one channel, forwards its request to the single downstream DMA write port, and routes the data handshake until the transfer completes. It then rearbitrates.

---
 rtl/dma_wr_arb.sv | 104 ++++++++++
 tb/tb_dma_wr_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wr_arb.sv
// Two-channel arbiter sharing one DMA write port between two frame-line write channels.
// Define DMA_WR_ARB_RR_EN for round-robin arbitration; otherwise channel 0 has fixed priority.
module dma_wr_arb #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 128
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic [2*AXI_ADDR_WIDTH-1:0] s_dma_waddr,
    input  logic [1:0]                  s_dma_wareq,
    input  logic [31:0]                 s_dma_wsize,
    output logic [1:0]                  s_dma_wbusy,
    input  logic [2*AXI_DATA_WIDTH-1:0] s_dma_wdata,
    output logic [1:0]                  s_dma_wvalid,
    input  logic [1:0]                  s_dma_wready,
    output logic [AXI_ADDR_WIDTH-1:0]   dma_waddr,
    output logic                        dma_wareq,
    output logic [15:0]                 dma_wsize,
    input  logic                        dma_wbusy,
    output logic [AXI_DATA_WIDTH-1:0]   dma_wdata,
    input  logic                        dma_wvalid,
    output logic                        dma_wready,
    output logic                        arb_grant,
    output logic                        arb_active
);

    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned DW = AXI_DATA_WIDTH;
    localparam int unsigned SW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   size_q, size_d;
    logic            winner_c;
    logic            xfer_c;
    logic [1:0]      grant_oh_c;

    always_comb begin
`ifdef DMA_WR_ARB_RR_EN
        // Contention goes to the channel that did not win last; a sole requester always wins.
        winner_c = (s_dma_wareq == 2'b11) ? ~grant_q : s_dma_wareq[1];
`else
        winner_c = ~s_dma_wareq[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        size_d  = size_q;
        case (state_q)
            IDLE: begin
                if (|s_dma_wareq) begin
                    state_d = REQ;
                    grant_d = winner_c;
                    addr_d  = winner_c ? s_dma_waddr[2*AW-1:AW] : s_dma_waddr[AW-1:0];
                    size_d  = winner_c ? s_dma_wsize[2*SW-1:SW] : s_dma_wsize[SW-1:0];
                end
            end
            REQ:     if (dma_wbusy)  state_d = XFER;
            XFER:    if (!dma_wbusy) state_d = DONE;
            // One idle-bound cycle so the released requester has dropped its request.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // Decode and data routing follow the registered state and grant.
    assign xfer_c       = (state_q == XFER);
    assign grant_oh_c   = grant_q ? 2'b10 : 2'b01;
    assign arb_active   = (state_q != IDLE);
    assign arb_grant    = grant_q;
    assign dma_wareq    = (state_q == REQ);
    assign dma_waddr    = addr_q;
    assign dma_wsize    = size_q;
    assign s_dma_wbusy  = arb_active ? grant_oh_c : 2'b00;
    assign dma_wdata    = xfer_c ? (grant_q ? s_dma_wdata[2*DW-1:DW] : s_dma_wdata[DW-1:0]) : '0;
    assign dma_wready   = xfer_c & s_dma_wready[grant_q];
    assign s_dma_wvalid = (xfer_c & dma_wvalid) ? grant_oh_c : 2'b00;

endmodule

// File: tb/tb_dma_wr_arb.sv
// Self-checking bench for dma_wr_arb: directed vectors, corner sequences and a randomized
// environment compared against a transaction-level arbitration model.
module tb_dma_wr_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic [2*AW-1:0]   s_dma_waddr;
    logic [1:0]        s_dma_wareq;
    logic [31:0]       s_dma_wsize;
    logic [1:0]        s_dma_wbusy;
    logic [2*DW-1:0]   s_dma_wdata;
    logic [1:0]        s_dma_wvalid;
    logic [1:0]        s_dma_wready;
    logic [AW-1:0]     dma_waddr;
    logic              dma_wareq;
    logic [15:0]       dma_wsize;
    logic              dma_wbusy;
    logic [DW-1:0]     dma_wdata;
    logic              dma_wvalid;
    logic              dma_wready;
    logic              arb_grant;
    logic              arb_active;

    dma_wr_arb #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .s_dma_waddr(s_dma_waddr), .s_dma_wareq(s_dma_wareq), .s_dma_wsize(s_dma_wsize),
        .s_dma_wbusy(s_dma_wbusy), .s_dma_wdata(s_dma_wdata), .s_dma_wvalid(s_dma_wvalid),
        .s_dma_wready(s_dma_wready), .dma_waddr(dma_waddr), .dma_wareq(dma_wareq),
        .dma_wsize(dma_wsize), .dma_wbusy(dma_wbusy), .dma_wdata(dma_wdata),
        .dma_wvalid(dma_wvalid), .dma_wready(dma_wready), .arb_grant(arb_grant),
        .arb_active(arb_active)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [15:0] size;
        int          dly;
        int          len;
        bit          imm;
        logic [1:0]  exp_busy;
        logic        exp_grant;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] cur_addr [2];
    logic [15:0] cur_size [2];
    int          want_pct [2];
    int          issued [2];
    int          served [2];
    logic        last_win;
    logic [1:0]  prev_busy;
    int          dly_cnt;
    int          len_cnt;
    logic        glog [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        s_dma_waddr = '0; s_dma_wareq = '0; s_dma_wsize = '0; s_dma_wdata = '0;
        s_dma_wready = '0; dma_wbusy = 1'b0; dma_wvalid = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic [31:0] a, input logic [15:0] s);
        s_dma_wareq[ch] = 1'b1;
        s_dma_waddr[ch*AW +: AW] = a;
        s_dma_wsize[ch*16 +: 16] = s;
        cur_addr[ch] = a;
        cur_size[ch] = s;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        step();
    endtask

    task automatic rand_data();
        for (int k = 0; k < int'(2*DW/32); k++) s_dma_wdata[k*32 +: 32] = $urandom;
    endtask

    // Arbitration rule taken straight from the policy description.
    function automatic logic pick(input logic [1:0] r, input logic last);
`ifdef DMA_WR_ARB_RR_EN
        if (r == 2'b11) return ~last;
        return r[1];
`else
        return r[0] ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        s_dma_wready = 2'b11;
        set_req(v.ch, v.addr, v.size);
        if (v.imm) dma_wbusy = 1'b1;
        step();
        chk("vec_wareq", 128'(dma_wareq), 128'(1));
        chk("vec_busy", 128'(s_dma_wbusy), 128'(v.exp_busy));
        chk("vec_addr", 128'(dma_waddr), 128'(v.addr));
        chk("vec_size", 128'(dma_wsize), 128'(v.size));
        chk("vec_grant", 128'(arb_grant), 128'(v.exp_grant));
        chk("vec_req_ready", 128'(dma_wready), 128'(0));
        s_dma_wareq[v.ch] = 1'b0;
        if (!v.imm) begin
            repeat (v.dly) begin
                step();
                chk("vec_req_hold", 128'(dma_wareq), 128'(1));
            end
            dma_wbusy = 1'b1;
        end
        step();
        chk("vec_xfer_wareq", 128'(dma_wareq), 128'(0));
        chk("vec_xfer_ready", 128'(dma_wready), 128'(1));
        repeat (v.len - 1) step();
        chk("vec_xfer_busy", 128'(s_dma_wbusy), 128'(v.exp_busy));
        dma_wbusy = 1'b0;
        step();
        chk("vec_done_active", 128'(arb_active), 128'(1));
        chk("vec_done_ready", 128'(dma_wready), 128'(0));
        step();
        chk("vec_idle_active", 128'(arb_active), 128'(0));
        chk("vec_idle_busy", 128'(s_dma_wbusy), 128'(0));
        chk("vec_addr_held", 128'(dma_waddr), 128'(v.addr));
        s_dma_wready = 2'b00;
    endtask

    // One cycle of the random environment: score the edge just taken, then drive.
    task automatic env_cycle();
        logic       w;
        logic [1:0] exp_busy;
        logic [1:0] own_oh;
        if (prev_busy == 2'b00) begin
            w = pick(s_dma_wareq, last_win);
            exp_busy = (s_dma_wareq == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
            chk("rnd_grant", 128'(s_dma_wbusy), 128'(exp_busy));
            if (s_dma_wareq != 2'b00) begin
                chk("rnd_addr", 128'(dma_waddr), 128'(cur_addr[w]));
                chk("rnd_size", 128'(dma_wsize), 128'(cur_size[w]));
                last_win = w;
                served[w]++;
                glog.push_back(w);
            end
        end else begin
            chk("rnd_hold", 128'((s_dma_wbusy == prev_busy) || (s_dma_wbusy == 2'b00)), 128'(1));
        end
        chk("rnd_arb_grant", 128'(arb_grant), 128'(last_win));
        prev_busy = s_dma_wbusy;

        for (int ch = 0; ch < 2; ch++) begin
            if (s_dma_wareq[ch] && s_dma_wbusy[ch]) begin
                s_dma_wareq[ch] = 1'b0;
            end else if (!s_dma_wareq[ch] && !s_dma_wbusy[ch] &&
                         int'($urandom_range(99)) < want_pct[ch]) begin
                set_req(ch, $urandom, 16'($urandom));
                issued[ch]++;
            end
        end

        if (dma_wareq && len_cnt == 0) begin
            dly_cnt = int'($urandom_range(2));
            len_cnt = int'($urandom_range(4, 1));
        end
        if (len_cnt > 0 && dly_cnt > 0) begin
            dly_cnt--;
            dma_wbusy = 1'b0;
        end else if (len_cnt > 0) begin
            dma_wbusy = 1'b1;
            len_cnt--;
        end else begin
            dma_wbusy = 1'b0;
        end

        rand_data();
        s_dma_wready = 2'($urandom);
        dma_wvalid = 1'($urandom);
        #1;
        own_oh = last_win ? 2'b10 : 2'b01;
        chk("rnd_wvalid_other", 128'(s_dma_wvalid & ~own_oh), 128'(0));
        if (dma_wready)
            chk("rnd_wdata", 128'(dma_wdata), 128'(s_dma_wdata[int'(last_win)*DW +: DW]));
    endtask

    initial begin
        vec_t tbl [4];
        logic [127:0] noise;

        RESETN = 1'b0;
        clear_inputs();
        #12;
        chk("rst_wareq", 128'(dma_wareq), 128'(0));
        chk("rst_wready", 128'(dma_wready), 128'(0));
        chk("rst_busy", 128'(s_dma_wbusy), 128'(0));
        chk("rst_wvalid", 128'(s_dma_wvalid), 128'(0));
        chk("rst_active", 128'(arb_active), 128'(0));
        chk("rst_waddr", 128'(dma_waddr), 128'(0));
        chk("rst_wsize", 128'(dma_wsize), 128'(0));
        chk("rst_wdata", 128'(dma_wdata), 128'(0));
        chk("rst_grant", 128'(arb_grant), 128'(1));
        @(negedge CLK);
        RESETN = 1'b1;
        step();

        tbl[0] = '{1, 32'h1000_0000, 16'h0780, 0, 20, 1'b0, 2'b10, 1'b1};
        tbl[1] = '{0, 32'hDEAD_BEE0, 16'h0010, 2,  3, 1'b0, 2'b01, 1'b0};
        tbl[2] = '{1, 32'h0000_0040, 16'hFFFF, 0,  1, 1'b1, 2'b10, 1'b1};
        tbl[3] = '{0, 32'hFFFF_FFF0, 16'h0001, 1,  5, 1'b1, 2'b01, 1'b0};
        foreach (tbl[i]) run_vec(tbl[i]);

        // DMA busy glitching while idle must not start anything.
        dma_wbusy = 1'b1;
        repeat (3) begin
            step();
            chk("glitch_active", 128'(arb_active), 128'(0));
        end
        dma_wbusy = 1'b0;
        step();

        // Data routing over 120 beats of channel 0.
        set_req(0, 32'h2000_0000, 16'h0078);
        s_dma_wready = 2'b11;
        step();
        chk("route_busy", 128'(s_dma_wbusy), 128'(2'b01));
        s_dma_wareq[0] = 1'b0;
        dma_wbusy = 1'b1;
        step();
        for (int i = 0; i < 120; i++) begin
            noise = {$urandom, $urandom, $urandom, $urandom};
            s_dma_wdata = {noise, 128'(i)};
            dma_wvalid = 1'b1;
            #1;
            chk("route_data", 128'(dma_wdata), 128'(i));
            chk("route_wvalid", 128'(s_dma_wvalid), 128'(2'b01));
            step();
        end
        dma_wbusy = 1'b0;
        step();
        chk("route_done_wvalid", 128'(s_dma_wvalid), 128'(0));
        chk("route_done_wdata", 128'(dma_wdata), 128'(0));
        dma_wvalid = 1'b0;
        s_dma_wready = 2'b00;
        step();

        // Channel 1 requests in the middle of a channel 0 transfer.
        set_req(0, 32'h3000_0000, 16'h0100);
        step();
        s_dma_wareq[0] = 1'b0;
        dma_wbusy = 1'b1;
        repeat (3) step();
        set_req(1, 32'h4000_0000, 16'h0200);
        repeat (3) step();
        chk("mid_xfer_busy", 128'(s_dma_wbusy), 128'(2'b01));
        dma_wbusy = 1'b0;
        step();
        chk("mid_done_busy", 128'(s_dma_wbusy), 128'(2'b01));
        step();
        chk("mid_idle_busy", 128'(s_dma_wbusy), 128'(0));
        step();
        chk("mid_ch1_busy", 128'(s_dma_wbusy), 128'(2'b10));
        chk("mid_ch1_wareq", 128'(dma_wareq), 128'(1));
        chk("mid_ch1_grant", 128'(arb_grant), 128'(1));
        chk("mid_ch1_addr", 128'(dma_waddr), 128'(32'h4000_0000));
        chk("mid_ch1_size", 128'(dma_wsize), 128'(16'h0200));
        s_dma_wareq[1] = 1'b0;
        dma_wbusy = 1'b1;
        step();
        dma_wbusy = 1'b0;
        repeat (2) step();
        chk("mid_end_active", 128'(arb_active), 128'(0));

        // Asynchronous reset in the middle of a transfer.
        set_req(1, 32'h5000_0000, 16'h0300);
        step();
        s_dma_wareq[1] = 1'b0;
        dma_wbusy = 1'b1;
        s_dma_wready = 2'b11;
        dma_wvalid = 1'b1;
        rand_data();
        step();
        RESETN = 1'b0;
        #1;
        chk("arst_wareq", 128'(dma_wareq), 128'(0));
        chk("arst_wready", 128'(dma_wready), 128'(0));
        chk("arst_busy", 128'(s_dma_wbusy), 128'(0));
        chk("arst_wvalid", 128'(s_dma_wvalid), 128'(0));
        chk("arst_active", 128'(arb_active), 128'(0));
        chk("arst_waddr", 128'(dma_waddr), 128'(0));
        chk("arst_wsize", 128'(dma_wsize), 128'(0));
        chk("arst_wdata", 128'(dma_wdata), 128'(0));
        chk("arst_grant", 128'(arb_grant), 128'(1));
        clear_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        step();
        set_req(0, 32'h6000_0000, 16'h0040);
        step();
        chk("post_rst_busy", 128'(s_dma_wbusy), 128'(2'b01));
        chk("post_rst_grant", 128'(arb_grant), 128'(0));
        chk("post_rst_addr", 128'(dma_waddr), 128'(32'h6000_0000));
        s_dma_wareq[0] = 1'b0;
        dma_wbusy = 1'b1;
        step();
        dma_wbusy = 1'b0;
        repeat (2) step();
        chk("post_rst_idle", 128'(arb_active), 128'(0));

        // Randomized traffic against the arbitration model.
        do_reset();
        last_win = 1'b1;
        prev_busy = 2'b00;
        dly_cnt = 0;
        len_cnt = 0;
        issued = '{0, 0};
        served = '{0, 0};
        want_pct = '{35, 35};
        repeat (400) begin
            step();
            env_cycle();
        end

        // Both channels requesting continuously.
        want_pct = '{100, 100};
        repeat (10) begin
            step();
            env_cycle();
        end
        glog.delete();
        for (int c = 0; c < 300 && glog.size() < 8; c++) begin
            step();
            env_cycle();
        end
        chk("cont_grant_count", 128'(glog.size() >= 8), 128'(1));
        if (glog.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
`ifdef DMA_WR_ARB_RR_EN
                if (k > 0) chk("cont_alternate", 128'(glog[k] != glog[k-1]), 128'(1));
`else
                chk("cont_fixed_ch0", 128'(glog[k]), 128'(0));
`endif
            end
        end

        // Drain: every request raised must have been granted.
        want_pct = '{0, 0};
        repeat (60) begin
            step();
            env_cycle();
        end
        chk("drain_ch0", 128'(served[0]), 128'(issued[0]));
        chk("drain_ch1", 128'(served[1]), 128'(issued[1]));
        chk("drain_pending", 128'(s_dma_wareq), 128'(0));
        chk("drain_idle", 128'(arb_active), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
